// File: rtl/pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_ch
// Brief    : Multi-channel PWM generator configured by 4-beat UDP parameter
//            frames. Optional macro PWM_SHADOW_UPDATE_EN defers parameter
//            updates to the channel's period wrap.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_ch #(
  parameter int          PWM_NUM      = 5,
  parameter logic [15:0] ID_PWM_PARAM = 16'd0,
  parameter int unsigned CLK_FREQ     = 32'd100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        rx_axis_udp_tdata,
  input  logic               rx_axis_udp_tvalid,
  input  logic               rx_axis_udp_tlast,
  output logic [PWM_NUM-1:0] pwm
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV1 = 3'd1,
    S_MUL  = 3'd2,
    S_DIV2 = 3'd3,
    S_LOAD = 3'd4
  } state_t;

  // ---------------------------------------------------------------- parser
  logic [1:0]  beat_q;
  logic        drop_q;
  logic        hdr_ok_q;
  logic [7:0]  ch_q;
  logic [31:0] freq_q;
  logic [7:0]  duty_q;
  logic        w_frame_ok;

  assign w_frame_ok = rx_axis_udp_tvalid && rx_axis_udp_tlast &&
                      (beat_q == 2'd3) && !drop_q && hdr_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q   <= 2'd0;
      drop_q   <= 1'b0;
      hdr_ok_q <= 1'b0;
      ch_q     <= 8'd0;
      freq_q   <= 32'd0;
      duty_q   <= 8'd0;
    end else if (rx_axis_udp_tvalid) begin
      case (beat_q)
        2'd0: begin
          hdr_ok_q <= (rx_axis_udp_tdata[31:16] == ID_PWM_PARAM) &&
                      ({24'd0, rx_axis_udp_tdata[15:8]} < 32'(PWM_NUM));
          ch_q     <= rx_axis_udp_tdata[15:8];
        end
        2'd1:    freq_q <= rx_axis_udp_tdata;
        2'd2:    duty_q <= rx_axis_udp_tdata[31:24];
        default: ;
      endcase
      // Beats past b3 without tlast poison the frame until tlast resyncs.
      if (rx_axis_udp_tlast) begin
        beat_q <= 2'd0;
        drop_q <= 1'b0;
      end else if (beat_q == 2'd3) begin
        drop_q <= 1'b1;
      end else begin
        beat_q <= beat_q + 2'd1;
      end
    end
  end

  // ------------------------------------------------------------ calculator
  state_t      state_q, state_d;
  logic [4:0]  step_q;
  logic [31:0] rem_q, quo_q, div_q;
  logic [31:0] res_per_q, res_high_q;
  logic [7:0]  calc_ch_q;
  logic        calc_en_q;
  logic [6:0]  calc_duty_q;

  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_nx, w_quo_nx;
  logic [39:0] w_prod;

  // Restoring step; rem_q may start non-zero so a 40-bit dividend whose
  // quotient fits 32 bits still completes in 32 steps.
  assign w_rem_sh = {rem_q, quo_q[31]};
  assign w_ge     = (w_rem_sh >= {1'b0, div_q});
  assign w_rem_nx = w_ge ? 32'(w_rem_sh - {1'b0, div_q}) : w_rem_sh[31:0];
  assign w_quo_nx = {quo_q[30:0], w_ge};
  assign w_prod   = 40'(res_per_q) * 40'(calc_duty_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_frame_ok) state_d = (freq_q == 32'd0) ? S_LOAD : S_DIV1;
      S_DIV1: if (step_q == 5'd31) state_d = S_MUL;
      S_MUL:  state_d = S_DIV2;
      S_DIV2: if (step_q == 5'd31) state_d = S_LOAD;
      S_LOAD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q      <= 5'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      div_q       <= 32'd0;
      res_per_q   <= 32'd0;
      res_high_q  <= 32'd0;
      calc_ch_q   <= 8'd0;
      calc_en_q   <= 1'b0;
      calc_duty_q <= 7'd0;
    end else begin
      case (state_q)
        S_IDLE: if (w_frame_ok) begin
          calc_ch_q   <= ch_q;
          calc_en_q   <= rx_axis_udp_tdata[24];
          calc_duty_q <= (duty_q > 8'd100) ? 7'd100 : duty_q[6:0];
          rem_q       <= 32'd0;
          quo_q       <= CLK_FREQ;
          div_q       <= freq_q;
          step_q      <= 5'd0;
          res_per_q   <= 32'd0;
          res_high_q  <= 32'd0;
        end
        S_DIV1: begin
          rem_q  <= w_rem_nx;
          quo_q  <= w_quo_nx;
          step_q <= step_q + 5'd1;
          if (step_q == 5'd31) res_per_q <= w_quo_nx;
        end
        S_MUL: begin
          rem_q  <= {24'd0, w_prod[39:32]};
          quo_q  <= w_prod[31:0];
          div_q  <= 32'd100;
          step_q <= 5'd0;
        end
        S_DIV2: begin
          rem_q  <= w_rem_nx;
          quo_q  <= w_quo_nx;
          step_q <= step_q + 5'd1;
          if (step_q == 5'd31) res_high_q <= w_quo_nx;
        end
        default: ;
      endcase
    end
  end

  logic w_load;
  logic w_load_en;
  assign w_load    = (state_q == S_LOAD);
  assign w_load_en = calc_en_q && (res_per_q != 32'd0);

  // -------------------------------------------------------------- channels
  for (genvar n = 0; n < PWM_NUM; n++) begin : g_ch
    logic [31:0] ch_per_q, ch_high_q, cnt_q;
    logic        en_q, out_q;
    logic        w_ld, w_wrap;

    assign w_ld   = w_load && (calc_ch_q == 8'(n));
    assign w_wrap = (cnt_q == 32'(ch_per_q - 32'd1));

`ifdef PWM_SHADOW_UPDATE_EN
    logic [31:0] sh_per_q, sh_high_q;
    logic        sh_en_q, pend_q, w_apply;

    // Pending values take over at the wrap, or at once when either the
    // running or the new setting is disabled.
    assign w_apply = pend_q && (!en_q || !sh_en_q || w_wrap);

    always_ff @(posedge clk) begin
      if (rst) begin
        sh_per_q  <= 32'd0;
        sh_high_q <= 32'd0;
        sh_en_q   <= 1'b0;
        pend_q    <= 1'b0;
        ch_per_q  <= 32'd0;
        ch_high_q <= 32'd0;
        en_q      <= 1'b0;
        cnt_q     <= 32'd0;
      end else begin
        if (w_ld) begin
          sh_per_q  <= res_per_q;
          sh_high_q <= res_high_q;
          sh_en_q   <= w_load_en;
          pend_q    <= 1'b1;
        end else if (w_apply) begin
          pend_q    <= 1'b0;
        end
        if (w_apply) begin
          ch_per_q  <= sh_per_q;
          ch_high_q <= sh_high_q;
          en_q      <= sh_en_q;
          cnt_q     <= 32'd0;
        end else if (en_q) begin
          cnt_q <= w_wrap ? 32'd0 : cnt_q + 32'd1;
        end else begin
          cnt_q <= 32'd0;
        end
      end
    end
`else
    always_ff @(posedge clk) begin
      if (rst) begin
        ch_per_q  <= 32'd0;
        ch_high_q <= 32'd0;
        en_q      <= 1'b0;
        cnt_q     <= 32'd0;
      end else if (w_ld) begin
        ch_per_q  <= res_per_q;
        ch_high_q <= res_high_q;
        en_q      <= w_load_en;
        cnt_q     <= 32'd0;
      end else if (en_q) begin
        cnt_q <= w_wrap ? 32'd0 : cnt_q + 32'd1;
      end else begin
        cnt_q <= 32'd0;
      end
    end
`endif

    always_ff @(posedge clk) begin
      if (rst) out_q <= 1'b0;
      else     out_q <= en_q && (cnt_q < ch_high_q);
    end

    assign pwm[n] = out_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_ch
// Brief    : Directed self-checking bench for pwm_multi_ch (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_ch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic [4:0]  pwm;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_multi_ch #(
    .PWM_NUM      (5),
    .ID_PWM_PARAM (16'd0),
    .CLK_FREQ     (100000000)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rx_axis_udp_tdata  (tdata),
    .rx_axis_udp_tvalid (tvalid),
    .rx_axis_udp_tlast  (tlast),
    .pwm                (pwm)
  );

  always #5 clk = ~clk;

  task automatic send_beat(input logic [31:0] d, input logic last);
    tdata  = d;
    tvalid = 1'b1;
    tlast  = last;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] id, input logic [7:0] ch,
                            input logic [31:0] freq, input logic [7:0] duty,
                            input logic en);
    send_beat({id, ch, 8'h00}, 1'b0);
    send_beat(freq, 1'b0);
    send_beat({duty, 24'h0}, 1'b0);
    send_beat({7'd0, en, 24'h0}, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a fresh rising edge on pwm[ch], then counts one high and one low run.
  task automatic measure(input int ch, output int hi, output int lo);
    logic prev;
    int   n;
    @(negedge clk);
    prev = pwm[ch];
    n    = 0;
    forever begin
      @(negedge clk);
      n++;
      if ((!prev && pwm[ch]) || n > 5000) break;
      prev = pwm[ch];
    end
    hi = 1;
    lo = 1;
    if (n > 5000) begin
      hi = -1;
      lo = -1;
      return;
    end
    forever begin
      @(negedge clk);
      if (!pwm[ch] || hi > 5000) break;
      hi++;
    end
    forever begin
      @(negedge clk);
      if (pwm[ch] || lo > 5000) break;
      lo++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (pwm !== 5'b0) begin n_fail++; $display("FAIL reset_pwm: got %b want 00000", pwm); end
    rst = 1'b0;
    idle(10);
    n_checks++;
    if (pwm !== 5'b0) begin n_fail++; $display("FAIL post_reset_pwm: got %b want 00000", pwm); end
  endtask

  task automatic test_basic;
    int n, hi, lo;
    send_frame(16'd0, 8'd1, 32'd100000, 8'd80, 1'b1);
    n = 0;
    while (n < 80 && pwm[1] !== 1'b1) begin @(negedge clk); n++; end
    n_checks++;
    if (pwm[1] !== 1'b1) begin n_fail++; $display("FAIL ch1_latency: pwm1 %b after %0d clk want 1 within 80", pwm[1], n); end
    measure(1, hi, lo);
    n_checks++;
    if (hi !== 800) begin n_fail++; $display("FAIL ch1_high: got %0d want 800", hi); end
    n_checks++;
    if (lo !== 200) begin n_fail++; $display("FAIL ch1_low: got %0d want 200", lo); end
  endtask

  task automatic test_duty_extremes;
    int bad0, bad4, hi, lo;
    send_frame(16'd0, 8'd0, 32'd100000, 8'd100, 1'b1);
    idle(80);
    send_frame(16'd0, 8'd4, 32'd100000, 8'd0, 1'b1);
    idle(80);
    bad0 = 0; bad4 = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (pwm[0] !== 1'b1) bad0++;
      if (pwm[4] !== 1'b0) bad4++;
    end
    n_checks++;
    if (bad0 != 0) begin n_fail++; $display("FAIL ch0_duty100: %0d low samples want 0", bad0); end
    n_checks++;
    if (bad4 != 0) begin n_fail++; $display("FAIL ch4_duty0: %0d high samples want 0", bad4); end
    measure(1, hi, lo);
    n_checks++;
    if (hi !== 800 || lo !== 200) begin n_fail++; $display("FAIL ch1_undisturbed: got %0d/%0d want 800/200", hi, lo); end
  endtask

  task automatic test_period_change;
    int hi, lo;
    send_frame(16'd0, 8'd2, 32'd55000, 8'd50, 1'b1);
    idle(80);
    send_frame(16'd0, 8'd3, 32'd55000, 8'd20, 1'b1);
    idle(80);
    measure(2, hi, lo);
    n_checks++;
    if (hi !== 909 || lo !== 909) begin n_fail++; $display("FAIL ch2_50pct: got %0d/%0d want 909/909", hi, lo); end
    measure(3, hi, lo);
    n_checks++;
    if (hi !== 363 || lo !== 1455) begin n_fail++; $display("FAIL ch3_20pct: got %0d/%0d want 363/1455", hi, lo); end
  endtask

  task automatic test_disable;
    int ones, hi, lo;
    send_frame(16'd0, 8'd1, 32'd55000, 8'd80, 1'b0);
    idle(80);
    ones = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (pwm[1] !== 1'b0) ones++;
    end
    n_checks++;
    if (ones != 0) begin n_fail++; $display("FAIL ch1_disable: %0d high samples want 0", ones); end
    n_checks++;
    if (pwm[0] !== 1'b1) begin n_fail++; $display("FAIL ch0_after_disable: got %b want 1", pwm[0]); end
    measure(2, hi, lo);
    n_checks++;
    if (hi !== 909 || lo !== 909) begin n_fail++; $display("FAIL ch2_after_disable: got %0d/%0d want 909/909", hi, lo); end
  endtask

  task automatic test_invalid;
    int bad;
    send_frame(16'd1, 8'd4, 32'd100000, 8'd100, 1'b1);
    idle(100);
    send_frame(16'd0, 8'd5, 32'd100000, 8'd100, 1'b1);
    idle(100);
    send_beat({16'd0, 8'd4, 8'h00}, 1'b0);
    send_beat(32'd100000, 1'b0);
    send_beat({8'd100, 24'h0}, 1'b1);
    idle(100);
    send_beat({16'd0, 8'd4, 8'h00}, 1'b0);
    send_beat(32'd100000, 1'b0);
    send_beat({8'd100, 24'h0}, 1'b0);
    send_beat({7'd0, 1'b1, 24'h0}, 1'b0);
    send_beat(32'd0, 1'b1);
    idle(100);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pwm[4] !== 1'b0 || pwm[0] !== 1'b1 || pwm[1] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL invalid_frames: %0d bad samples pwm=%b want 0", bad, pwm); end
    send_frame(16'd0, 8'd4, 32'd100000, 8'd100, 1'b1);
    idle(80);
    n_checks++;
    if (pwm[4] !== 1'b1) begin n_fail++; $display("FAIL valid_after_invalid: pwm4 %b want 1", pwm[4]); end
  endtask

  task automatic test_corner;
    int bad;
    send_frame(16'd0, 8'd4, 32'd0, 8'd100, 1'b1);
    idle(80);
    send_frame(16'd0, 8'd0, 32'd200000000, 8'd100, 1'b1);
    idle(80);
    send_frame(16'd0, 8'd3, 32'd100000, 8'd150, 1'b1);
    idle(80);
    bad = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (pwm[4] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL freq_zero: %0d high samples want 0", bad); end
    n_checks++;
    if (pwm[0] !== 1'b0) begin n_fail++; $display("FAIL freq_too_high: pwm0 %b want 0", pwm[0]); end
    bad = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (pwm[3] !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL duty150_clamp: %0d low samples want 0", bad); end
  endtask

  task automatic test_reset_midframe;
    send_beat({16'd0, 8'd0, 8'h00}, 1'b0);
    send_beat(32'd100000, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pwm !== 5'b0) begin n_fail++; $display("FAIL midframe_reset: got %b want 00000", pwm); end
    rst = 1'b0;
    send_beat({8'd100, 24'h0}, 1'b0);
    send_beat({7'd0, 1'b1, 24'h0}, 1'b1);
    idle(100);
    n_checks++;
    if (pwm !== 5'b0) begin n_fail++; $display("FAIL resync_after_reset: got %b want 00000", pwm); end
  endtask

  task automatic test_back_to_back;
    send_frame(16'd0, 8'd2, 32'd100000, 8'd100, 1'b1);
    send_frame(16'd0, 8'd3, 32'd100000, 8'd100, 1'b1);
    idle(150);
    n_checks++;
    if (pwm !== 5'b00100) begin n_fail++; $display("FAIL busy_drop: got %b want 00100", pwm); end
    send_frame(16'd0, 8'd3, 32'd100000, 8'd100, 1'b1);
    idle(80);
    n_checks++;
    if (pwm !== 5'b01100) begin n_fail++; $display("FAIL after_busy: got %b want 01100", pwm); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty_extremes();
    test_period_change();
    test_disable();
    test_invalid();
    test_corner();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
